mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its ALU result, destination address and control strobes (mem_inst, store, WR, link).
- Performs word loads and stores over a req/gnt/rvalid data-memory handshake, then drives the register-file write port.
- Stalls the execute stage while a memory transaction is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- LINK_REG, 7, register index written by link instructions.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a valid instruction this cycle
- ex_data  in  DATA_W  ALU result; memory address for mem ops, writeback value otherwise
- ex_store_data  in  DATA_W  store data (srcB)
- ex_addr_dest  in  3  destination register
- ex_WR  in  1  register write enable
- ex_mem_inst  in  1  load/store instruction
- ex_store  in  1  1 = store, 0 = load (valid when ex_mem_inst)
- ex_link  in  1  write return PC to LINK_REG
- ex_pc_ret  in  16  return PC for link
- stall  out  1  EX must hold its current instruction
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  word address, bits [1:0] forced 0
- dmem_wdata  out  DATA_W  store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read data
- rf_wen  out  1  register write strobe, one-cycle pulse
- rf_waddr  out  3  register write address
- rf_wdata  out  DATA_W  register write data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset: state IDLE; every output register 0, so stall, dmem_req, rf_wen, rf_waddr and rf_wdata are all 0.
- stall = (state != IDLE), combinational. An instruction is accepted when ex_valid=1 and state=IDLE.
- IDLE, accept, non-mem instruction:
  - Next cycle, rf_wen = ex_WR | ex_link.
  - If ex_link: rf_waddr = LINK_REG, rf_wdata = {zero-extend ex_pc_ret}. Link has priority over WR.
  - Otherwise: rf_waddr = ex_addr_dest, rf_wdata = ex_data.
  - Latency 1 cycle. State stays IDLE, so back-to-back ALU instructions run at 1 per cycle.
- IDLE, accept, mem instruction: latch address, store data, dest, store and WR; go to REQ. No rf write.
- REQ:
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata driven from latched values and held stable until gnt.
  - On dmem_gnt, store: go IDLE; no writeback; stall drops the following cycle.
  - On dmem_gnt, load: go WAIT; dmem_req=0 from the next cycle.
- WAIT: on dmem_rvalid, rf_wen <= latched WR, rf_waddr <= latched dest, rf_wdata <= dmem_rdata; go IDLE. A new instruction may be accepted in that same IDLE cycle.
- Ignored inputs: dmem_gnt outside REQ; dmem_rvalid outside WAIT; ex_valid while stall=1 (EX holds it, and it is accepted once IDLE).
- Link on a mem instruction is not supported; ex_link is ignored when ex_mem_inst=1.
- rf_wen is high for exactly one cycle per writeback. rf_waddr and rf_wdata hold their last values when rf_wen=0.
- Reset mid-transaction: immediate return to IDLE with dmem_req=0; the pending transaction is dropped and no writeback occurs.
- Unbounded wait for gnt or rvalid; no timeout.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output align_err (1 bit, sticky, cleared only by reset).
  - A mem instruction with address bits [1:0] != 0 sets align_err the next cycle, issues no dmem_req, performs no writeback, and stays IDLE (no stall).
- When undefined: no align_err port; address bits [1:0] are silently forced to 0 on dmem_addr.

Test Plan:
- ALU op: ex_valid=1, ex_WR=1, ex_addr_dest=3, ex_data=0x1234 -> next cycle rf_wen=1, rf_waddr=3, rf_wdata=0x1234, stall=0.
- Link: ex_link=1, ex_WR=1, ex_addr_dest=2, ex_pc_ret=0x00A4 -> rf_waddr=7, rf_wdata=0x000000A4; one-cycle pulse only.
- Load with gnt delayed 2 cycles and rvalid 3 cycles after gnt: addr=0x40, dest=5, rdata=0xDEADBEEF -> dmem_req high 3 cycles with addr 0x40 and we=0; stall high throughout; rf write of 0xDEADBEEF to r5 the cycle after rvalid.
- Store with immediate gnt: addr=0x80, ex_store_data=0xCAFEF00D -> one-cycle dmem_req with we=1 and wdata 0xCAFEF00D; no rf_wen; stall high exactly 1 cycle.
- Load then back-to-back ALU op held by EX: ALU op retires the cycle after load writeback; spurious rvalid in IDLE causes no rf_wen.
- resetn pulled low in WAIT -> dmem_req=0, stall=0, rf_wen=0 immediately; later rvalid is ignored. With MEM_ALIGN_CHECK_EN, a load at 0x42 -> align_err=1, no dmem_req.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Brief    : MEM/WB stage; word load/store over req/gnt/rvalid, then RF write.
//            Optional MEM_ALIGN_CHECK_EN adds a sticky align_err output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W   = 32,
  parameter int LINK_REG = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [2:0]        ex_addr_dest,
  input  logic              ex_WR,
  input  logic              ex_mem_inst,
  input  logic              ex_store,
  input  logic              ex_link,
  input  logic [15:0]       ex_pc_ret,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              align_err,
`endif
  output logic              rf_wen,
  output logic [2:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:2]   r_addr;
  logic [DATA_W-1:0]   r_store_data;
  logic [2:0]          r_dest;
  logic                r_store;
  logic                r_wr;
  logic                r_rf_wen;
  logic [2:0]          r_rf_waddr;
  logic [DATA_W-1:0]   r_rf_wdata;

  logic                w_accept;
  logic                w_misaligned;
  logic                w_mem_start;

  assign w_accept = ex_valid && (r_state == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  logic r_align_err;
  assign w_misaligned = (ex_data[1:0] != 2'b00);
  assign align_err    = r_align_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_align_err <= 1'b0;
    end else if (w_accept && ex_mem_inst && w_misaligned) begin
      r_align_err <= 1'b1;
    end
  end
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_mem_start = w_accept && ex_mem_inst && !w_misaligned;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_mem_start) w_state_next = ST_REQ;
      ST_REQ:  if (dmem_gnt)    w_state_next = r_store ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (dmem_rvalid) w_state_next = ST_IDLE;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_store_data <= '0;
      r_dest       <= '0;
      r_store      <= 1'b0;
      r_wr         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_mem_start) begin
        r_addr       <= ex_data[DATA_W-1:2];
        r_store_data <= ex_store_data;
        r_dest       <= ex_addr_dest;
        r_store      <= ex_store;
        r_wr         <= ex_WR;
      end
    end
  end

  // Write address/data only move on an actual write so they hold otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_wen <= 1'b0;
      if (w_accept && !ex_mem_inst && (ex_WR || ex_link)) begin
        r_rf_wen <= 1'b1;
        if (ex_link) begin
          r_rf_waddr <= 3'(LINK_REG);
          r_rf_wdata <= {{(DATA_W-16){1'b0}}, ex_pc_ret};
        end else begin
          r_rf_waddr <= ex_addr_dest;
          r_rf_wdata <= ex_data;
        end
      end else if ((r_state == ST_WAIT) && dmem_rvalid && r_wr) begin
        r_rf_wen   <= 1'b1;
        r_rf_waddr <= r_dest;
        r_rf_wdata <= dmem_rdata;
      end
    end
  end

  assign stall      = (r_state != ST_IDLE);
  assign dmem_req   = (r_state == ST_REQ);
  assign dmem_we    = r_store;
  assign dmem_addr  = {r_addr, 2'b00};
  assign dmem_wdata = r_store_data;
  assign rf_wen     = r_rf_wen;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Brief    : Self-checking bench for mem_wb_stage (directed + random ops).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [31:0] ex_data;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_addr_dest;
  logic        ex_WR;
  logic        ex_mem_inst;
  logic        ex_store;
  logic        ex_link;
  logic [15:0] ex_pc_ret;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_wen;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: last architecturally written RF port values and sticky error.
  logic [2:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_known;
  bit          m_align;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .LINK_REG(7)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_data(ex_data), .ex_store_data(ex_store_data),
    .ex_addr_dest(ex_addr_dest), .ex_WR(ex_WR), .ex_mem_inst(ex_mem_inst),
    .ex_store(ex_store), .ex_link(ex_link), .ex_pc_ret(ex_pc_ret),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hold(input string tag);
    if (m_known) begin
      chk({tag, "_waddr_hold"}, 32'(rf_waddr), 32'(m_waddr));
      chk({tag, "_wdata_hold"}, rf_wdata, m_wdata);
    end
  endtask

  task automatic chk_align(input string tag);
`ifdef MEM_ALIGN_CHECK_EN
    chk({tag, "_align_err"}, 32'(align_err), 32'(m_align));
`endif
  endtask

  // Random EX traffic while stalled; the stage must ignore it.
  task automatic junk_ex();
    ex_valid      = 1'($urandom_range(0, 1));
    ex_mem_inst   = 1'($urandom_range(0, 1));
    ex_store      = 1'($urandom_range(0, 1));
    ex_WR         = 1'($urandom_range(0, 1));
    ex_link       = 1'($urandom_range(0, 1));
    ex_data       = $urandom;
    ex_store_data = $urandom;
    ex_addr_dest  = 3'($urandom);
    ex_pc_ret     = 16'($urandom);
  endtask

  task automatic alu_op(input bit wr, input bit link, input logic [2:0] dest,
                        input logic [31:0] data, input logic [15:0] pc);
    ex_valid = 1'b1; ex_mem_inst = 1'b0; ex_store = 1'($urandom_range(0, 1));
    ex_WR = wr; ex_link = link; ex_addr_dest = dest; ex_data = data;
    ex_store_data = $urandom; ex_pc_ret = pc;
    dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    chk("alu_stall_pre", 32'(stall), 32'd0);
    step();
    ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("alu_wen", 32'(rf_wen), 32'(wr | link));
    if (wr | link) begin
      m_waddr = link ? 3'd7 : dest;
      m_wdata = link ? {16'h0, pc} : data;
      m_known = 1'b1;
      chk("alu_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("alu_wdata", rf_wdata, m_wdata);
    end else begin
      m_known = 1'b0;
    end
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(dmem_req), 32'd0);
    chk_align("alu");
  endtask

  task automatic mem_op(input bit st, input bit wr, input logic [2:0] dest,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input int gd, input int rd, input logic [31:0] rdata);
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    ex_valid = 1'b1; ex_mem_inst = 1'b1; ex_store = st; ex_WR = wr;
    ex_link = 1'($urandom_range(0, 1)); ex_addr_dest = dest; ex_data = addr;
    ex_store_data = sdata; ex_pc_ret = 16'($urandom);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    step();
`ifdef MEM_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) begin
      ex_valid = 1'b0;
      m_align = 1'b1;
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_wen", 32'(rf_wen), 32'd0);
      chk_align("mis");
      return;
    end
`endif
    for (int i = 0; i <= gd; i++) begin
      junk_ex();
      chk("req_req", 32'(dmem_req), 32'd1);
      chk("req_we", 32'(dmem_we), 32'(st));
      chk("req_addr", dmem_addr, exp_addr);
      if (st) chk("req_wdata", dmem_wdata, sdata);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_wen", 32'(rf_wen), 32'd0);
      dmem_gnt = (i == gd);
      dmem_rvalid = 1'($urandom_range(0, 1));
      step();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (st) begin
      ex_valid = 1'b0;
      chk("st_stall", 32'(stall), 32'd0);
      chk("st_req", 32'(dmem_req), 32'd0);
      chk("st_wen", 32'(rf_wen), 32'd0);
      chk_hold("st");
      chk_align("st");
      return;
    end
    for (int j = 0; j <= rd; j++) begin
      junk_ex();
      chk("wait_req", 32'(dmem_req), 32'd0);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_wen", 32'(rf_wen), 32'd0);
      dmem_gnt = 1'($urandom_range(0, 1));
      dmem_rvalid = (j == rd);
      dmem_rdata = (j == rd) ? rdata : $urandom;
      step();
    end
    ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("ld_wen", 32'(rf_wen), 32'(wr));
    if (wr) begin
      m_waddr = dest; m_wdata = rdata; m_known = 1'b1;
      chk("ld_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("ld_wdata", rf_wdata, m_wdata);
    end else begin
      m_known = 1'b0;
    end
    chk("ld_stall", 32'(stall), 32'd0);
    chk_align("ld");
  endtask

  task automatic idle_cycle();
    ex_valid = 1'b0;
    dmem_gnt = 1'($urandom_range(0, 1)); dmem_rvalid = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    step();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("idle_wen", 32'(rf_wen), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);
    chk("idle_req", 32'(dmem_req), 32'd0);
    chk_hold("idle");
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    resetn = 1'b0; ex_valid = 1'b0; ex_data = '0; ex_store_data = '0;
    ex_addr_dest = '0; ex_WR = 1'b0; ex_mem_inst = 1'b0; ex_store = 1'b0;
    ex_link = 1'b0; ex_pc_ret = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    m_waddr = '0; m_wdata = '0; m_known = 1'b1; m_align = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk_align("rst");
    @(negedge clk) resetn = 1'b1;
    step();

    // Directed scenarios
    alu_op(1'b1, 1'b0, 3'd3, 32'h0000_1234, 16'h0);
    alu_op(1'b1, 1'b1, 3'd2, 32'h5555_AAAA, 16'h00A4);
    idle_cycle();
    mem_op(1'b0, 1'b1, 3'd5, 32'h40, 32'h0, 2, 3, 32'hDEAD_BEEF);
    alu_op(1'b1, 1'b0, 3'd1, 32'h0BAD_F00D, 16'h0);
    mem_op(1'b1, 1'b0, 3'd0, 32'h80, 32'hCAFE_F00D, 0, 0, 32'h0);
    idle_cycle();
    idle_cycle();

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 4))
        0, 1: alu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     3'($urandom), $urandom, 16'($urandom));
        2: mem_op(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), rand_addr(),
                  $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        3: mem_op(1'b1, 1'($urandom_range(0, 1)), 3'($urandom), rand_addr(),
                  $urandom, $urandom_range(0, 3), 0, 32'h0);
        default: idle_cycle();
      endcase
    end

    // Reset while waiting for read data
    ex_valid = 1'b1; ex_mem_inst = 1'b1; ex_store = 1'b0; ex_WR = 1'b1;
    ex_link = 1'b0; ex_addr_dest = 3'd6; ex_data = 32'h100;
    step();
    ex_valid = 1'b0; dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_wen", 32'(rf_wen), 32'd0);
    chk("mid_rst_waddr", 32'(rf_waddr), 32'd0);
    m_waddr = '0; m_wdata = '0; m_known = 1'b1; m_align = 1'b0;
    chk_align("mid_rst");
    @(negedge clk) resetn = 1'b1;
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_rvalid = 1'b0;
    chk("post_rst_wen", 32'(rf_wen), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk_hold("post_rst");

    // Unaligned load: flagged with the check enabled, otherwise low bits dropped
    mem_op(1'b0, 1'b1, 3'd4, 32'h42, 32'h0, 0, 1, 32'h7777_8888);
    idle_cycle();
    chk_align("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
